// File: rtl/zero_extend_4to16_pkg.sv
// Shared datapath width constants for the immediate-field extenders.
package zero_extend_4to16_pkg;

  // Native word width of the datapath; extended immediates default to this.
  localparam int DATA_W = 16;

  // Width of the short immediate field fed to the extender.
  localparam int IMM4_W = 4;

endpackage : zero_extend_4to16_pkg

// File: rtl/zero_extend_4to16_zext_comb.sv
// Pure combinational zero-extend of an IN_W-bit field to OUT_W bits.
// Upper bits are tied to constant 0, so X/Z on i only reaches o[IN_W-1:0].
module zext_comb #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  i,
  output logic [OUT_W-1:0] o
);

  // A narrower output would silently drop field bits, so refuse to build.
  if (OUT_W < IN_W) begin : g_bad_width
    $error("zext_comb: OUT_W (%0d) must be >= IN_W (%0d)", OUT_W, IN_W);
  end

  if (OUT_W == IN_W) begin : g_pass
    // Equal widths: nothing to pad, output is the field itself.
    assign o = i;
  end else if (OUT_W > IN_W) begin : g_pad
    localparam int PAD_W = OUT_W - IN_W;
    // Pad above the field with zeros; never replicate the field MSB.
    assign o = {{PAD_W{1'b0}}, i};
  end else begin : g_none
    assign o = '0;
  end

endmodule : zext_comb

// File: rtl/zero_extend_4to16.sv
// Immediate-field constant generator: 4-bit unsigned field to 16-bit operand.
// O is combinational and ignores CLK/Reset; O_q is a one-cycle registered copy
// whose only state is cleared asynchronously by Reset.
module zero_extend_4to16
  import zero_extend_4to16_pkg::*;
#(
  parameter int IN_W  = IMM4_W,
  parameter int OUT_W = DATA_W
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [IN_W-1:0]  I,
  output logic [OUT_W-1:0] O,
  output logic [OUT_W-1:0] O_q
);

  logic [OUT_W-1:0] ext;

  zext_comb #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_zext (
    .i (I),
    .o (ext)
  );

  assign O = ext;

  // Register the extended value for pipelined consumers; Reset clears it at once.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      O_q <= '0;
    end else begin
      O_q <= ext;
    end
  end

endmodule : zero_extend_4to16

// File: tb/tb_zero_extend_4to16.sv
// Directed bench for zero_extend_4to16 (default 4->16 and an 8->16 instance).
module tb_zero_extend_4to16;

  logic        CLK;
  logic        Reset;
  logic [3:0]  I;
  logic [15:0] O;
  logic [15:0] O_q;

  logic [7:0]  I8;
  logic [15:0] O8;
  logic [15:0] O_q8;

  logic        clk_en;
  int          n_pass;
  int          n_total;

  zero_extend_4to16 dut (
    .CLK   (CLK),
    .Reset (Reset),
    .I     (I),
    .O     (O),
    .O_q   (O_q)
  );

  zero_extend_4to16 #(
    .IN_W  (8),
    .OUT_W (16)
  ) dut8 (
    .CLK   (CLK),
    .Reset (Reset),
    .I     (I8),
    .O     (O8),
    .O_q   (O_q8)
  );

  // Gated clock, period 10 ns; stopped while clk_en is low.
  initial begin
    CLK = 1'b0;
    forever begin
      #5;
      if (clk_en) CLK = ~CLK;
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    clk_en  = 1'b0;
    Reset   = 1'b1;
    I       = 4'h0;
    I8      = 8'h00;
    #1;
    check("reset_O_q", O_q, 16'h0000);
    check("reset_O_q8", O_q8, 16'h0000);

    // Exhaustive combinational sweep with clock stopped and reset held.
    for (int k = 0; k < 16; k++) begin
      I = k[3:0];
      #10;
      check($sformatf("sweep_%0d", k), O, {12'h000, k[3:0]});
    end

    // MSB set must not sign-extend.
    I = 4'b1000;
    #1;
    check("msb_8", O, 16'h0008);
    I = 4'hF;
    #1;
    check("all_ones", O, 16'h000F);

    // O follows I with CLK stopped and Reset high; O_q stays cleared.
    I = 4'h3;
    #1;
    check("indep_O_3", O, 16'h0003);
    check("indep_Oq_3", O_q, 16'h0000);
    I = 4'hA;
    #1;
    check("indep_O_A", O, 16'h000A);
    check("indep_Oq_A", O_q, 16'h0000);

    // Start the clock while still in reset: O_q must hold 0 across edges.
    clk_en = 1'b1;
    @(posedge CLK);
    #1;
    check("hold_in_reset", O_q, 16'h0000);

    // Register latency.
    @(negedge CLK);
    Reset = 1'b0;
    I     = 4'h5;
    @(posedge CLK);
    #1;
    check("lat_edge_n", O_q, 16'h0005);
    #3;
    I = 4'h9;
    #1;
    check("lat_mid_cycle", O_q, 16'h0005);
    check("lat_O_comb", O, 16'h0009);
    @(posedge CLK);
    #1;
    check("lat_edge_n1", O_q, 16'h0009);

    // Asynchronous reset between edges.
    @(negedge CLK);
    I = 4'h7;
    @(posedge CLK);
    #1;
    check("pre_async_7", O_q, 16'h0007);
    #2;
    Reset = 1'b1;
    #1;
    check("async_clear", O_q, 16'h0000);
    check("async_O_live", O, 16'h0007);
    @(negedge CLK);
    Reset = 1'b0;
    I     = 4'h2;
    #1;
    check("after_deassert_no_edge", O_q, 16'h0000);
    @(posedge CLK);
    #1;
    check("first_edge_load_2", O_q, 16'h0002);

    // Wider-field instance.
    I8 = 8'hA5;
    #1;
    check("w8_O_A5", O8, 16'h00A5);
    @(posedge CLK);
    #1;
    check("w8_Oq_A5", O_q8, 16'h00A5);
    I8 = 8'h80;
    #1;
    check("w8_O_80", O8, 16'h0080);

    clk_en = 1'b0;
    #20;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_zero_extend_4to16
